y86_seq_controller: RTL and testbench



---
 rtl/y86_pkg.sv | 57 +++++
 rtl/y86_seq_controller_if.sv | 35 +++
 rtl/y86_mem_wait_timer.sv | 35 +++
 rtl/y86_seq_controller.sv | 147 ++++++++++++++
 tb/tb_y86_seq_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared types and constants for the sequential Y86-64 controller.
// Stage states, stat codes, icodes and small decode helpers.
package y86_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT,
    S_ERR
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Instructions that touch data memory.
  function automatic logic uses_mem(input logic [3:0] ic);
    return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL,
                      I_RET, I_PUSHQ, I_POPQ};
  endfunction

  // One-hot enables {pc,w,m,e,d,f} for a state.
  function automatic logic [5:0] stage_en(input state_e s);
    logic [5:0] en;
    en = 6'b0;
    unique case (s)
      S_FETCH:     en = 6'b000001;
      S_DECODE:    en = 6'b000010;
      S_EXECUTE:   en = 6'b000100;
      S_MEMORY:    en = 6'b001000;
      S_WRITEBACK: en = 6'b010000;
      S_PCUPD:     en = 6'b100000;
      S_HALT:      en = 6'b000000;
      S_ERR:       en = 6'b000000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/y86_seq_controller_if.sv
// Controller <-> stage bus: fetch flags, PC select, data-memory
// handshake, stage enables and status.
interface y86_seq_controller_if;
  logic [3:0]  icode;
  logic        hlt;
  logic        imem_error;
  logic        instr_invalid;
  logic [63:0] new_pc;
  logic        mem_ack;
  logic        dmem_error;
  logic [63:0] pc;
  logic        f_en;
  logic        d_en;
  logic        e_en;
  logic        m_en;
  logic        w_en;
  logic        pc_en;
  logic        mem_req;
  logic [2:0]  stat;
  logic        busy;

  modport master (
    input  icode, hlt, imem_error, instr_invalid,
    input  new_pc, mem_ack, dmem_error,
    output pc, f_en, d_en, e_en, m_en, w_en, pc_en,
    output mem_req, stat, busy
  );

  modport slave (
    output icode, hlt, imem_error, instr_invalid,
    output new_pc, mem_ack, dmem_error,
    input  pc, f_en, d_en, e_en, m_en, w_en, pc_en,
    input  mem_req, stat, busy
  );
endinterface

// File: rtl/y86_mem_wait_timer.sv
// Saturating 5-bit wait counter for the MEMORY stage.
// timeout fires while enabled and the count equals LIMIT.
module y86_mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [4:0] cnt_q;
  logic [4:0] cnt_d;

  // Clear outside MEMORY, count up and saturate inside.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 5'd0;
    else if (en && cnt_q != 5'h1f)
      cnt_d = cnt_q + 5'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= 5'd0;
    else
      cnt_q <= cnt_d;
  end

  assign timeout = en && (cnt_q == 5'(LIMIT));

endmodule

// File: rtl/y86_seq_controller.sv
// Stage sequencer and PC owner for the sequential Y86-64 core.
// Optional perf counters under `Y86_PERF_CNT_EN.
import y86_pkg::*;

module y86_seq_controller #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
`ifdef Y86_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  y86_seq_controller_if.master bus
);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [5:0]  en_q, en_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;
  logic        in_mem;
  logic        timeout;

  assign in_mem = (state_q == S_MEMORY);

  y86_mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_mem),
    .en      (in_mem),
    .timeout (timeout)
  );

  // Next-state, PC and status; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (bus.imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_ERR;
        end else if (bus.instr_invalid) begin
          stat_d  = STAT_INS;
          state_d = S_ERR;
        end else if (bus.hlt) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE:
        state_d = uses_mem(bus.icode) ? S_MEMORY
                                      : S_WRITEBACK;
      S_MEMORY: begin
        if (bus.mem_ack) begin
          if (bus.dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_ERR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (timeout) begin
          stat_d  = STAT_ADR;
          state_d = S_ERR;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d    = bus.new_pc;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
    endcase
    en_d      = stage_en(state_d);
    mem_req_d = (state_d == S_MEMORY);
    busy_d    = !(state_d == S_HALT || state_d == S_ERR);
  end

  // FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      en_q      <= 6'b000001;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      en_q      <= en_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.f_en    = en_q[0];
  assign bus.d_en    = en_q[1];
  assign bus.e_en    = en_q[2];
  assign bus.m_en    = en_q[3];
  assign bus.w_en    = en_q[4];
  assign bus.pc_en   = en_q[5];
  assign bus.mem_req = mem_req_q;
  assign bus.stat    = stat_q;
  assign bus.busy    = busy_q;

`ifdef Y86_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;

  // Busy cycles and retired (or halting) instructions.
  always_comb begin
    cyc_d = busy_q ? cyc_q + 32'd1 : cyc_q;
    ins_d = ins_q;
    if (state_q == S_PCUPD ||
        (state_d == S_HALT && state_q != S_HALT))
      ins_d = ins_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`endif

endmodule

// File: tb/tb_y86_seq_controller.sv
// Scoreboard bench for y86_seq_controller.
// Expected enables/status are queued as stimulus is driven.
module tb_y86_seq_controller;

  localparam logic [63:0] RPC = 64'h10;
  localparam int          TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_seq_controller_if bus();

`ifdef Y86_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  y86_seq_controller #(
    .RESET_PC    (RPC),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef Y86_PERF_CNT_EN
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt),
`endif
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [5:0]  en_q[$];
  logic [5:0]  en_v;

  assign en_v = {bus.pc_en, bus.w_en, bus.m_en,
                 bus.e_en, bus.d_en, bus.f_en};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      0: return bus.pc;
      1: return 64'(en_v);
      2: return 64'(bus.stat);
      3: return 64'(bus.busy);
      default: return 64'(bus.mem_req);
    endcase
  endfunction

  task automatic push(input string tag, input int sel,
                      input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.icode         = 4'h1;
    bus.hlt           = 1'b0;
    bus.imem_error    = 1'b0;
    bus.instr_invalid = 1'b0;
    bus.new_pc        = 64'h0;
    bus.mem_ack       = 1'b0;
    bus.dmem_error    = 1'b0;
  endtask

  task automatic push_reset(input string tag);
    push({tag, "_pc"}, 0, RPC);
    push({tag, "_en"}, 1, 64'h01);
    push({tag, "_stat"}, 2, 64'd1);
    push({tag, "_busy"}, 3, 64'd1);
    push({tag, "_mreq"}, 4, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    tick();
    push_reset("rst");
    drain();
`ifdef Y86_PERF_CNT_EN
    check("rst_cyc", 64'(cycle_cnt), 64'd0);
    check("rst_ins", 64'(instr_cnt), 64'd0);
`endif
    rst_n = 1'b1;
  endtask

  // Run one instruction from FETCH; k<0 means no ack ever.
  task automatic run(input logic [3:0] ic,
                     input logic [63:0] npc,
                     input int k, input bit derr,
                     input bit stray, output int mc);
    bit mem;
    mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    clear_in();
    bus.icode      = ic;
    bus.new_pc     = npc;
    bus.mem_ack    = stray;
    bus.dmem_error = stray;
    en_q.push_back(6'b000010);
    en_q.push_back(6'b000100);
    if (!mem) begin
      en_q.push_back(6'b010000);
      en_q.push_back(6'b100000);
    end else if (k < 0) begin
      for (int i = 0; i <= TMO; i++)
        en_q.push_back(6'b001000);
      en_q.push_back(6'b000000);
    end else begin
      for (int i = 0; i <= k; i++)
        en_q.push_back(6'b001000);
      if (derr) begin
        en_q.push_back(6'b000000);
      end else begin
        en_q.push_back(6'b010000);
        en_q.push_back(6'b100000);
      end
    end
    mc = 0;
    while (en_q.size() > 0) begin
      tick();
      check("en_seq", 64'(en_v), 64'(en_q.pop_front()));
      if (bus.mem_req) begin
        mc++;
        bus.mem_ack    = (mc == k + 1);
        bus.dmem_error = derr && (mc == k + 1);
      end else begin
        bus.mem_ack    = stray;
        bus.dmem_error = stray;
      end
    end
    bus.mem_ack    = 1'b0;
    bus.dmem_error = 1'b0;
  endtask

  task automatic finish_ok(input string tag,
                           input logic [63:0] npc);
    tick();
    push({tag, "_pc"}, 0, npc);
    push({tag, "_en"}, 1, 64'h01);
    push({tag, "_stat"}, 2, 64'd1);
    drain();
  endtask

  task automatic push_stop(input string tag,
                           input logic [2:0] st,
                           input logic [63:0] p);
    push({tag, "_stat"}, 2, 64'(st));
    push({tag, "_busy"}, 3, 64'd0);
    push({tag, "_en"}, 1, 64'd0);
    push({tag, "_mreq"}, 4, 64'd0);
    push({tag, "_pc"}, 0, p);
  endtask

  int mc;

  initial begin
    clear_in();
    rst_n = 1'b0;

    // Reset state and a plain nop.
    do_reset();
    push("nop_pcu_pc", 0, RPC);
    run(4'h1, 64'h11, 0, 1'b0, 1'b0, mc);
    drain();
    finish_ok("nop", 64'h11);

    // Memory op with ack k=3 after MEMORY entry.
    run(4'h4, 64'h20, 3, 1'b0, 1'b0, mc);
    check("mreq_cycles", 64'(mc), 64'd4);
    finish_ok("rmmov", 64'h20);

    // Stray ack with error outside MEMORY is ignored.
    run(4'h6, 64'h2a, 0, 1'b0, 1'b1, mc);
    check("stray_mreq", 64'(mc), 64'd0);
    finish_ok("stray", 64'h2a);

    // Other memory icodes, k=0.
    run(4'hB, 64'h31, 0, 1'b0, 1'b0, mc);
    check("pop_mreq", 64'(mc), 64'd1);
    finish_ok("pop", 64'h31);

    // Halt after one instruction; pc frozen.
    clear_in();
    bus.hlt    = 1'b1;
    bus.new_pc = 64'hdead;
    tick();
    tick();
    push_stop("halt", 3'd2, 64'h31);
    drain();
    repeat (20) tick();
    push_stop("halt20", 3'd2, 64'h31);
    drain();
`ifdef Y86_PERF_CNT_EN
    check("halt_ins", 64'(instr_cnt), 64'd5);
`endif

    // ADR wins over INS in DECODE.
    do_reset();
    bus.imem_error    = 1'b1;
    bus.instr_invalid = 1'b1;
    bus.hlt           = 1'b1;
    tick();
    tick();
    push_stop("adr_ins", 3'd3, RPC);
    drain();

    // INS wins over HLT.
    do_reset();
    bus.instr_invalid = 1'b1;
    bus.hlt           = 1'b1;
    tick();
    tick();
    push_stop("ins", 3'd4, RPC);
    drain();

    // Timeout: no ack at all.
    do_reset();
    run(4'h5, 64'h77, -1, 1'b0, 1'b0, mc);
    check("tmo_cycles", 64'(mc), 64'(TMO + 1));
    push_stop("tmo", 3'd3, RPC);
    drain();

    // Ack with dmem_error: no PC update.
    do_reset();
    run(4'h1, 64'h40, 0, 1'b0, 1'b0, mc);
    finish_ok("pre", 64'h40);
    run(4'h9, 64'h99, 1, 1'b1, 1'b0, mc);
    check("derr_cycles", 64'(mc), 64'd2);
    push_stop("derr", 3'd3, 64'h40);
    drain();

    // Reset in the middle of a MEMORY wait.
    do_reset();
    run(4'h1, 64'h55, 0, 1'b0, 1'b0, mc);
    finish_ok("pre2", 64'h55);
    clear_in();
    bus.icode = 4'h8;
    repeat (4) tick();
    push("mid_mreq", 4, 64'd1);
    push("mid_pc", 0, 64'h55);
    drain();
    rst_n = 1'b0;
    tick();
    push_reset("midrst");
    drain();
`ifdef Y86_PERF_CNT_EN
    check("midrst_cyc", 64'(cycle_cnt), 64'd0);
    check("midrst_ins", 64'(instr_cnt), 64'd0);
`endif
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
